// File: rtl/si1143_gesture_sequencer.sv
// Si1143 proximity sensor sequencer: boot delay, register init, interrupt-driven PS1..PS3 readout.
// Optional `define SI1143_POLL_EN adds a forced read after POLL_CYC idle cycles.
module si1143_gesture_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'h5A,
  parameter int unsigned STARTUP_CYC = 1_250_000,
  parameter int unsigned RETRY_CYC   = 500_000,
  parameter int unsigned POLL_CYC    = 2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor_int_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_nack_last,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  input  logic        rsp_nack,
  output logic [15:0] ps1,
  output logic [15:0] ps2,
  output logic [15:0] ps3,
  output logic        data_valid,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;
  localparam logic [7:0] ADDR_W   = {DEV_ADDR, 1'b0};
  localparam logic [7:0] ADDR_R   = {DEV_ADDR, 1'b1};

`ifdef SI1143_POLL_EN
  localparam int unsigned CNT_MAX0 = (STARTUP_CYC > RETRY_CYC) ? STARTUP_CYC : RETRY_CYC;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > POLL_CYC) ? CNT_MAX0 : POLL_CYC;
`else
  localparam int unsigned CNT_MAX  = (STARTUP_CYC > RETRY_CYC) ? STARTUP_CYC : RETRY_CYC;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYC - 1);
`ifdef SI1143_POLL_EN
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_BOOT, S_INIT, S_IDLE, S_READ, S_CLEAR, S_ABORT, S_RETRY
  } state_t;

  function automatic logic [15:0] rom_pair(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_pair = {8'h07, 8'h17};
      3'd1:    rom_pair = {8'h03, 8'h01};
      3'd2:    rom_pair = {8'h04, 8'h1C};
      3'd3:    rom_pair = {8'h08, 8'h84};
      3'd4:    rom_pair = {8'h0F, 8'hFF};
      3'd5:    rom_pair = {8'h18, 8'h0F};
      default: rom_pair = 16'h0000;
    endcase
  endfunction

  // Returns {nack_last, op, wdata} for command `step` of the transaction owned by `st`.
  function automatic logic [10:0] cmd_lookup(input state_t st, input logic [3:0] step,
                                             input logic [15:0] pair);
    cmd_lookup = {1'b0, OP_STOP, 8'h00};
    case (st)
      S_INIT: begin
        case (step)
          4'd0:    cmd_lookup = {1'b0, OP_START, 8'h00};
          4'd1:    cmd_lookup = {1'b0, OP_WRITE, ADDR_W};
          4'd2:    cmd_lookup = {1'b0, OP_WRITE, pair[15:8]};
          4'd3:    cmd_lookup = {1'b0, OP_WRITE, pair[7:0]};
          default: cmd_lookup = {1'b0, OP_STOP, 8'h00};
        endcase
      end
      S_READ: begin
        case (step)
          4'd0:    cmd_lookup = {1'b0, OP_START, 8'h00};
          4'd1:    cmd_lookup = {1'b0, OP_WRITE, ADDR_W};
          4'd2:    cmd_lookup = {1'b0, OP_WRITE, 8'h26};
          4'd3:    cmd_lookup = {1'b0, OP_START, 8'h00};
          4'd4:    cmd_lookup = {1'b0, OP_WRITE, ADDR_R};
          4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
                   cmd_lookup = {(step == 4'd10), OP_READ, 8'h00};
          default: cmd_lookup = {1'b0, OP_STOP, 8'h00};
        endcase
      end
      S_CLEAR: begin
        case (step)
          4'd0:    cmd_lookup = {1'b0, OP_START, 8'h00};
          4'd1:    cmd_lookup = {1'b0, OP_WRITE, ADDR_W};
          4'd2:    cmd_lookup = {1'b0, OP_WRITE, 8'h21};
          4'd3:    cmd_lookup = {1'b0, OP_WRITE, 8'h1C};
          default: cmd_lookup = {1'b0, OP_STOP, 8'h00};
        endcase
      end
      default: cmd_lookup = {1'b0, OP_STOP, 8'h00};
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outst_q, outst_d;
  logic             sync1_q, sync2_q;
  logic [5:0][7:0]  shadow_q, shadow_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_op_q, cmd_op_d;
  logic [7:0]       cmd_wdata_q, cmd_wdata_d;
  logic             cmd_nl_q, cmd_nl_d;
  logic [15:0]      ps1_q, ps1_d, ps2_q, ps2_d, ps3_q, ps3_d;
  logic             data_valid_q, data_valid_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [10:0]      cmd_now;
  logic [3:0]       last_step;
  logic             irq_pending;

  assign irq_pending = ~sync2_q;

  // Next-state logic: transaction walker, handshake and result publishing.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    outst_d      = outst_q;
    shadow_d     = shadow_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_op_d     = cmd_op_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_nl_d     = cmd_nl_q;
    ps1_d        = ps1_q;
    ps2_d        = ps2_q;
    ps3_d        = ps3_q;
    data_valid_d = 1'b0;
    init_done_d  = init_done_q;
    err_d        = err_q;
    cmd_now      = cmd_lookup(state_q, step_q, rom_pair(idx_q));

    case (state_q)
      S_READ:  last_step = 4'd11;
      S_ABORT: last_step = 4'd0;
      default: last_step = 4'd4;
    endcase

    case (state_q)
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = S_INIT;
          step_d  = 4'd0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RETRY: begin
        if (cnt_q == RETRY_LAST) begin
          state_d = S_INIT;
          step_d  = 4'd0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (irq_pending) begin
          state_d = S_READ;
          step_d  = 4'd0;
        end
`ifdef SI1143_POLL_EN
        else if (cnt_q == POLL_LAST) begin
          state_d = S_READ;
          step_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = S_IDLE;
        end
`endif
      end
      S_INIT, S_READ, S_CLEAR, S_ABORT: begin
        if (!cmd_valid_q && !outst_q) begin
          cmd_valid_d                         = 1'b1;
          {cmd_nl_d, cmd_op_d, cmd_wdata_d}   = cmd_now;
        end else if (cmd_valid_q) begin
          if (cmd_ready) begin
            cmd_valid_d = 1'b0;
            outst_d     = 1'b1;
          end else begin
            cmd_valid_d = 1'b1;
          end
        end else if (rsp_valid) begin
          outst_d = 1'b0;
          // A WRITE NACK aborts whatever transaction is running; the abort STOP itself cannot NACK.
          if (cmd_op_q == OP_WRITE && rsp_nack && state_q != S_ABORT) begin
            state_d     = S_ABORT;
            step_d      = 4'd0;
            err_d       = 1'b1;
            init_done_d = 1'b0;
          end else if (step_q == last_step) begin
            step_d = 4'd0;
            case (state_q)
              S_INIT: begin
                if (idx_q == 3'd5) begin
                  state_d     = S_IDLE;
                  init_done_d = 1'b1;
                  cnt_d       = '0;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end
              S_READ:  state_d = S_CLEAR;
              S_CLEAR: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                ps1_d        = {shadow_q[1], shadow_q[0]};
                ps2_d        = {shadow_q[3], shadow_q[2]};
                ps3_d        = {shadow_q[5], shadow_q[4]};
                data_valid_d = 1'b1;
              end
              S_ABORT: begin
                state_d = S_RETRY;
                cnt_d   = '0;
              end
              default: state_d = S_BOOT;
            endcase
          end else begin
            step_d = step_q + 4'd1;
            if (cmd_op_q == OP_READ) begin
              shadow_d[3'(step_q - 4'd5)] = rsp_rdata;
            end else begin
              shadow_d = shadow_q;
            end
          end
        end else begin
          outst_d = outst_q;
        end
      end
      default: state_d = S_BOOT;
    endcase

    busy_d = !(state_d == S_BOOT || state_d == S_IDLE || state_d == S_RETRY);
  end

  // State and output registers; sensor interrupt synchronizer idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      step_q       <= 4'd0;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      outst_q      <= 1'b0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      shadow_q     <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= 2'd0;
      cmd_wdata_q  <= 8'h00;
      cmd_nl_q     <= 1'b0;
      ps1_q        <= 16'h0000;
      ps2_q        <= 16'h0000;
      ps3_q        <= 16'h0000;
      data_valid_q <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      outst_q      <= outst_d;
      sync1_q      <= sensor_int_n;
      sync2_q      <= sync1_q;
      shadow_q     <= shadow_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_nl_q     <= cmd_nl_d;
      ps1_q        <= ps1_d;
      ps2_q        <= ps2_d;
      ps3_q        <= ps3_d;
      data_valid_q <= data_valid_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_op        = cmd_op_q;
  assign cmd_wdata     = cmd_wdata_q;
  assign cmd_nack_last = cmd_nl_q;
  assign ps1           = ps1_q;
  assign ps2           = ps2_q;
  assign ps3           = ps3_q;
  assign data_valid    = data_valid_q;
  assign init_done     = init_done_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_si1143_gesture_sequencer.sv
// Self-checking bench: randomized I2C-master/slave model plus a transaction-level expected command stream.
module tb_si1143_gesture_sequencer;

  localparam int STARTUP = 50;
  localparam int RETRY   = 80;
  localparam int POLL    = 200;
  localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_WRITE = 2'd2, OP_READ = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sensor_int_n = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_rdata = 8'h00;
  logic        rsp_nack = 1'b0;
  logic        cmd_valid, cmd_nack_last, data_valid, init_done, busy, err;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic [15:0] ps1, ps2, ps3;

  si1143_gesture_sequencer #(
    .DEV_ADDR(7'h5A), .STARTUP_CYC(STARTUP), .RETRY_CYC(RETRY), .POLL_CYC(POLL)
  ) dut (
    .clk(clk), .reset(reset), .sensor_int_n(sensor_int_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .cmd_nack_last(cmd_nack_last), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .ps1(ps1), .ps2(ps2), .ps3(ps3), .data_valid(data_valid),
    .init_done(init_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] cmd_log[$];
  logic [10:0] exp_q[$];
  logic [7:0]  rd_q[$];
  int          stall_max = 3;
  int          force_stall = 0;
  logic [7:0]  nack_on = 8'h00;
  bit          nack_armed = 1'b0;
  int          dv_count = 0;
  int          max_gap = 0;
  int          t_last = 0;
  logic [15:0] exp_ps1 = 16'h0, exp_ps2 = 16'h0, exp_ps3 = 16'h0;
  logic [7:0]  rom_reg [6] = '{8'h07, 8'h03, 8'h04, 8'h08, 8'h0F, 8'h18};
  logic [7:0]  rom_val [6] = '{8'h17, 8'h01, 8'h1C, 8'h84, 8'hFF, 8'h0F};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_cmd(input logic [1:0] op, input logic [7:0] d, input logic nl);
    exp_q.push_back({nl, op, d});
  endfunction

  function automatic void exp_write_txn(input logic [7:0] ra, input logic [7:0] val);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hB4, 1'b0);
    push_cmd(OP_WRITE, ra, 1'b0);
    push_cmd(OP_WRITE, val, 1'b0);
    push_cmd(OP_STOP, 8'h00, 1'b0);
  endfunction

  function automatic void exp_init();
    for (int i = 0; i < 6; i++) exp_write_txn(rom_reg[i], rom_val[i]);
  endfunction

  function automatic void exp_read();
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hB4, 1'b0);
    push_cmd(OP_WRITE, 8'h26, 1'b0);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hB5, 1'b0);
    for (int i = 0; i < 6; i++) push_cmd(OP_READ, 8'h00, i == 5);
    push_cmd(OP_STOP, 8'h00, 1'b0);
  endfunction

  function automatic void exp_nacked_txn(input logic [7:0] ra);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hB4, 1'b0);
    push_cmd(OP_WRITE, ra, 1'b0);
    push_cmd(OP_STOP, 8'h00, 1'b0);
  endfunction

  task automatic compare_log(input string tag);
    check_eq({tag, "_len"}, cmd_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      check_eq($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_q[i]);
    cmd_log.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cmd_valid"}, cmd_valid, 0);
    check_eq({tag, "_cmd_op"}, cmd_op, 0);
    check_eq({tag, "_cmd_wdata"}, cmd_wdata, 0);
    check_eq({tag, "_nack_last"}, cmd_nack_last, 0);
    check_eq({tag, "_ps1"}, ps1, 0);
    check_eq({tag, "_ps2"}, ps2, 0);
    check_eq({tag, "_ps3"}, ps3, 0);
    check_eq({tag, "_data_valid"}, data_valid, 0);
    check_eq({tag, "_init_done"}, init_done, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  // I2C master + Si1143 slave model: stalls ready, answers with delay, serves read bytes, injects NACK.
  task automatic master();
    logic [10:0] snap = 11'h0;
    logic [7:0]  r_data = 8'h00;
    logic        r_nack = 1'b0;
    int cnt = 0, phase = 0, dly = 0, gap = 0;
    forever begin
      @(negedge clk);
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (reset) begin
        phase  = 0;
        t_last = cyc;
      end else begin
        case (phase)
          0: if (cmd_valid) begin
               gap = cyc - t_last;
               if (gap > max_gap) max_gap = gap;
               snap  = {cmd_nack_last, cmd_op, cmd_wdata};
               cnt   = (force_stall > 0) ? force_stall : int'($urandom_range(stall_max, 0));
               phase = 1;
             end
          1: begin
               check_eq("cmd_stable", {cmd_valid, cmd_nack_last, cmd_op, cmd_wdata}, {1'b1, snap});
               cnt--;
             end
          2: begin
               check_eq("one_outstanding", cmd_valid, 0);
               cmd_log.push_back({(snap[9:8] == OP_READ) ? snap[10] : 1'b0, snap[9:8],
                                  (snap[9:8] == OP_WRITE) ? snap[7:0] : 8'h00});
               r_nack = 1'b0;
               r_data = 8'h00;
               if (snap[9:8] == OP_READ) r_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
               if (snap[9:8] == OP_WRITE && nack_armed && snap[7:0] == nack_on) begin
                 r_nack     = 1'b1;
                 nack_armed = 1'b0;
               end
               dly   = $urandom_range(2, 0);
               phase = 3;
             end
          default: ;
        endcase
        if (phase == 1 && cnt <= 0) begin
          cmd_ready = 1'b1;
          phase     = 2;
        end
        if (phase == 3) begin
          if (dly == 0) begin
            rsp_valid = 1'b1;
            rsp_rdata = r_data;
            rsp_nack  = r_nack;
            t_last    = cyc;
            phase     = 0;
          end else begin
            dly--;
          end
        end
      end
    end
  endtask

  task automatic dv_mon();
    logic dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        dv_count++;
        check_eq("dv_single_cycle", dv_prev, 0);
      end
      dv_prev = data_valid;
    end
  endtask

  task automatic watchdog();
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 4000 && !init_done; i++) @(negedge clk);
    check_eq({tag, "_init_done"}, init_done, 1);
  endtask

  task automatic read_once(input logic [7:0] b [6], input string tag);
    int dv0 = dv_count;
    for (int i = 0; i < 6; i++) rd_q.push_back(b[i]);
    exp_read();
    exp_write_txn(8'h21, 8'h1C);
    sensor_int_n = 1'b0;
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    check_eq({tag, "_busy"}, busy, 1);
    sensor_int_n = 1'b1;
    for (int i = 0; i < 3000 && dv_count == dv0; i++) @(negedge clk);
    exp_ps1 = {b[1], b[0]};
    exp_ps2 = {b[3], b[2]};
    exp_ps3 = {b[5], b[4]};
    repeat (5) @(negedge clk);
    check_eq({tag, "_dv_count"}, dv_count, dv0 + 1);
    check_eq({tag, "_ps1"}, ps1, exp_ps1);
    check_eq({tag, "_ps2"}, ps2, exp_ps2);
    check_eq({tag, "_ps3"}, ps3, exp_ps3);
    check_eq({tag, "_idle"}, busy, 0);
    compare_log(tag);
  endtask

  logic [7:0] bset [6];
  logic [7:0] bset2 [6];
  int t0, delay, dv0, t_idle;

  initial begin
    fork
      master();
      dv_mon();
      watchdog();
    join_none

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    t0 = cyc;
    for (int i = 0; i < STARTUP + 20 && !cmd_valid; i++) @(negedge clk);
    delay = cyc - t0;
    check_eq("boot_delay_in_window", (delay >= STARTUP && delay <= STARTUP + 2), 1);
    exp_init();
    wait_init("boot");
    repeat (3) @(negedge clk);
    check_eq("boot_busy", busy, 0);
    check_eq("boot_err", err, 0);
    compare_log("init");

    bset = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    read_once(bset, "fixed");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) bset[i] = 8'($urandom);
      read_once(bset, $sformatf("rand%0d", r));
    end

    force_stall = 20;
    for (int i = 0; i < 6; i++) bset[i] = 8'($urandom);
    read_once(bset, "stall20");
    force_stall = 0;

    // Level-sensitive request: holding the interrupt low across a CLEAR yields a second read.
    for (int i = 0; i < 6; i++) begin
      bset[i]  = 8'($urandom);
      bset2[i] = 8'($urandom);
    end
    for (int i = 0; i < 6; i++) rd_q.push_back(bset[i]);
    for (int i = 0; i < 6; i++) rd_q.push_back(bset2[i]);
    exp_read(); exp_write_txn(8'h21, 8'h1C);
    exp_read(); exp_write_txn(8'h21, 8'h1C);
    dv0 = dv_count;
    sensor_int_n = 1'b0;
    for (int i = 0; i < 3000 && dv_count == dv0; i++) @(negedge clk);
    sensor_int_n = 1'b1;
    for (int i = 0; i < 3000 && dv_count < dv0 + 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    exp_ps1 = {bset2[1], bset2[0]};
    exp_ps2 = {bset2[3], bset2[2]};
    exp_ps3 = {bset2[5], bset2[4]};
    check_eq("level_dv_count", dv_count, dv0 + 2);
    check_eq("level_ps1", ps1, exp_ps1);
    check_eq("level_ps3", ps3, exp_ps3);
    compare_log("level");

    // NACK on the read pointer write: abort, re-init, no publish, results retained.
    nack_on = 8'h26; nack_armed = 1'b1;
    exp_nacked_txn(8'h26);
    exp_init();
    dv0 = dv_count;
    sensor_int_n = 1'b0;
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    sensor_int_n = 1'b1;
    for (int i = 0; i < 500 && init_done; i++) @(negedge clk);
    check_eq("rdnack_init_cleared", init_done, 0);
    check_eq("rdnack_err", err, 1);
    wait_init("rdnack");
    repeat (3) @(negedge clk);
    check_eq("rdnack_no_dv", dv_count, dv0);
    check_eq("rdnack_ps1_kept", ps1, exp_ps1);
    check_eq("rdnack_ps2_kept", ps2, exp_ps2);
    compare_log("rdnack");

    // Reset while the 4th READ byte is in flight.
    for (int i = 0; i < 6; i++) rd_q.push_back(8'($urandom));
    sensor_int_n = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      automatic int nr = 0;
      foreach (cmd_log[k]) if (cmd_log[k][9:8] == OP_READ) nr++;
      if (nr == 3 && cmd_valid && cmd_op == OP_READ) break;
      @(negedge clk);
    end
    check_eq("midrst_reached_4th_read", {cmd_valid, cmd_op}, {1'b1, OP_READ});
    dv0 = dv_count;
    reset = 1'b1;
    sensor_int_n = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    rd_q.delete(); cmd_log.delete(); exp_q.delete();
    reset = 1'b0;
    exp_init();
    wait_init("midrst");
    repeat (3) @(negedge clk);
    check_eq("midrst_no_dv", dv_count, dv0);
    check_eq("midrst_ps1_zero", ps1, 0);
    compare_log("midrst");

    // NACK on INT_CFG register byte during init: STOP, retry wait, restart from HW_KEY.
    reset = 1'b1;
    @(negedge clk);
    cmd_log.delete(); exp_q.delete();
    nack_on = 8'h03; nack_armed = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    max_gap = 0;
    exp_write_txn(8'h07, 8'h17);
    exp_nacked_txn(8'h03);
    exp_init();
    for (int i = 0; i < 2000 && !err; i++) @(negedge clk);
    check_eq("initnack_err", err, 1);
    check_eq("initnack_init_done", init_done, 0);
    wait_init("initnack");
    t_idle = cyc;
    check_eq("initnack_err_sticky", err, 1);
    check_eq("initnack_retry_gap", (max_gap >= RETRY && max_gap <= RETRY + 4), 1);
    compare_log("initnack");

`ifdef SI1143_POLL_EN
    for (int i = 0; i < 6; i++) rd_q.push_back(8'($urandom));
    dv0 = dv_count;
    for (int i = 0; i < 2 * POLL && !cmd_valid; i++) @(negedge clk);
    delay = cyc - t_idle;
    check_eq("poll_delay_in_window", (delay >= POLL - 1 && delay <= POLL + 3), 1);
    for (int i = 0; i < 3000 && dv_count == dv0; i++) @(negedge clk);
    check_eq("poll_dv", dv_count, dv0 + 1);
`else
    repeat (3 * POLL) @(negedge clk);
    check_eq("nopoll_no_cmds", cmd_log.size(), 0);
    check_eq("nopoll_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
